// File: rtl/tinyalu_arbiter.sv
// rtl/tinyalu_arbiter.sv - round-robin arbiter sharing one TinyALU among NUM_REQ requesters
module tinyalu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    input  logic [3*NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_result,
    output logic                   rsp_err,
    output logic                   alu_start,
    output logic [2:0]             alu_op,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    input  logic                   alu_done,
    input  logic [15:0]            alu_result
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] sel_idx;
    logic          sel_found;
    logic [IW:0]   cand;
    logic [2:0]    sel_op;
    logic [2:0]    op_q;
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic [15:0]   result_q;
    logic          err_q;
    logic [WW-1:0] wdog;

    // Round-robin search: first valid requester strictly after the last grant, wrapping
    always_comb begin
        sel_idx   = ptr;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!sel_found && req_valid[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
        sel_op = req_op[3*sel_idx +: 3];
    end

    // Accept pulse only from IDLE; held low while reset is asserted
    always_comb begin
        req_ready = '0;
        if (reset_n && state == S_IDLE && sel_found) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    // Response and ALU pins decode from state so an async reset clears them at once
    always_comb begin
        rsp_valid = '0;
        if (state == S_RESP) begin
            rsp_valid[gnt_q] = 1'b1;
        end
        rsp_result = (state == S_RESP) ? result_q : 16'h0000;
        rsp_err    = (state == S_RESP) ? err_q : 1'b0;
        alu_start  = (state == S_BUSY);
        alu_op     = alu_start ? op_q : 3'b000;
        alu_a      = alu_start ? a_q : 8'h00;
        alu_b      = alu_start ? b_q : 8'h00;
    end

    // Main control: grant, run the ALU under watchdog, then present one response cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            ptr      <= IW'(NUM_REQ - 1);
            gnt_q    <= '0;
            op_q     <= 3'b000;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            result_q <= 16'h0000;
            err_q    <= 1'b0;
            wdog     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        gnt_q <= sel_idx;
                        ptr   <= sel_idx;
                        op_q  <= sel_op;
                        a_q   <= req_a[8*sel_idx +: 8];
                        b_q   <= req_b[8*sel_idx +: 8];
                        wdog  <= '0;
                        case (sel_op)
                            OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
                                state <= S_BUSY;
                            end
                            OP_NOP: begin
                                result_q <= 16'h0000;
                                err_q    <= 1'b0;
                                state    <= S_RESP;
                            end
                            default: begin
                                result_q <= 16'h0000;
                                err_q    <= 1'b1;
                                state    <= S_RESP;
                            end
                        endcase
                    end
                end
                S_BUSY: begin
                    wdog <= wdog + 1'b1;
                    if (alu_done) begin
                        result_q <= alu_result;
                        err_q    <= 1'b0;
                        state    <= S_RESP;
                    end else if (wdog == WW'(TIMEOUT - 1)) begin
                        result_q <= 16'h0000;
                        err_q    <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    wdog  <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb/tb_tinyalu_arbiter.sv - directed self-checking bench for tinyalu_arbiter
module tb_tinyalu_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_a;
    logic [8*N-1:0]  req_b;
    logic [3*N-1:0]  req_op;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_result;
    logic            rsp_err;
    logic            alu_start;
    logic [2:0]      alu_op;
    logic [7:0]      alu_a;
    logic [7:0]      alu_b;
    logic            alu_done;
    logic [15:0]     alu_result;

    logic            hang;
    int              alu_cnt;
    int              n_checks;
    int              n_fail;

    tinyalu_arbiter #(.NUM_REQ(N), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: single-cycle ops done in first start cycle, mul in third
    always @(posedge clk) begin
        if (!alu_start) alu_cnt <= 0;
        else            alu_cnt <= alu_cnt + 1;
    end

    always_comb begin
        alu_done = alu_start && !hang && (alu_cnt == ((alu_op == 3'b100) ? 2 : 0));
        case (alu_op)
            3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            3'b010:  alu_result = {8'h00, alu_a & alu_b};
            3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
            3'b100:  alu_result = {8'h00, alu_a} * {8'h00, alu_b};
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*idx +: 3] = op;
        req_a[8*idx +: 8]  = a;
        req_b[8*idx +: 8]  = b;
        req_valid[idx]     = 1'b1;
    endtask

    task automatic do_req(input string tag, input int idx, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input int exp_busy,
                          input logic [15:0] exp_res, input logic exp_err);
        int   lat;
        int   busy;
        logic hold_ok;
        logic [N-1:0] onehot;
        onehot = '0;
        onehot[idx] = 1'b1;
        req_valid = '0;
        set_req(idx, op, a, b);
        #1;
        check_eq({tag, "_ready"}, req_ready, onehot);
        step();
        req_valid = '0;
        lat = 1;
        busy = 0;
        hold_ok = 1'b1;
        while (rsp_valid == '0 && lat < 40) begin
            if (alu_start) begin
                busy++;
                if (alu_op !== op || alu_a !== a || alu_b !== b) hold_ok = 1'b0;
            end
            step();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_busy"}, busy, exp_busy);
        check_eq({tag, "_hold"}, hold_ok, 1'b1);
        check_eq({tag, "_rsp_valid"}, rsp_valid, onehot);
        check_eq({tag, "_result"}, rsp_result, exp_res);
        check_eq({tag, "_err"}, rsp_err, exp_err);
        check_eq({tag, "_start_low"}, {alu_start, alu_op, alu_a, alu_b}, 20'h0);
        step();
        check_eq({tag, "_rsp_clear"}, rsp_valid, '0);
    endtask

    logic [7:0] fa [4];
    logic [7:0] fb [4];
    logic [15:0] fx [4];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        hang      = 1'b0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        fa[0] = 8'hA5; fb[0] = 8'h0F; fx[0] = 16'h00AA;
        fa[1] = 8'h3C; fb[1] = 8'h55; fx[1] = 16'h0069;
        fa[2] = 8'h0F; fb[2] = 8'hFF; fx[2] = 16'h00F0;
        fa[3] = 8'hF0; fb[3] = 8'h33; fx[3] = 16'h00C3;

        #1;
        check_eq("rst_ready", req_ready, '0);
        check_eq("rst_rsp", {rsp_valid, rsp_result, rsp_err}, '0);
        check_eq("rst_alu", {alu_start, alu_op, alu_a, alu_b}, '0);
        do_reset();

        do_req("add0", 0, 3'b001, 8'h10, 8'h20, 2, 1, 16'h0030, 1'b0);
        do_req("mul2", 2, 3'b100, 8'hFF, 8'hFF, 4, 3, 16'hFE01, 1'b0);
        do_req("rst1", 1, 3'b111, 8'h12, 8'h34, 1, 0, 16'h0000, 1'b1);
        do_req("nop1", 1, 3'b000, 8'h12, 8'h34, 1, 0, 16'h0000, 1'b0);
        do_req("unsup1", 1, 3'b101, 8'h01, 8'h01, 1, 0, 16'h0000, 1'b1);

        hang = 1'b1;
        do_req("tmo3", 3, 3'b001, 8'h01, 8'h02, 17, 16, 16'h0000, 1'b1);
        hang = 1'b0;
        do_req("and0", 0, 3'b010, 8'h22, 8'h33, 2, 1, 16'h0022, 1'b0);

        // Fairness: all requesters hold xor continuously from reset release
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 3'b011, fa[i], fb[i]);
        for (int g = 0; g < 6; g++) begin
            logic [N-1:0] oh;
            oh = '0;
            oh[g % N] = 1'b1;
            #1;
            check_eq($sformatf("rr_ready%0d", g), req_ready, oh);
            step();
            step();
            check_eq($sformatf("rr_rsp%0d", g), rsp_valid, oh);
            check_eq($sformatf("rr_res%0d", g), rsp_result, fx[g % N]);
            step();
        end
        req_valid = '0;
        step();

        // Reset asserted while a mul is in BUSY
        set_req(2, 3'b100, 8'h07, 8'h09);
        #1;
        check_eq("abort_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        step();
        check_eq("abort_busy", alu_start, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("abort_alu", {alu_start, alu_op, alu_a, alu_b}, '0);
        check_eq("abort_rsp", rsp_valid, '0);
        set_req(0, 3'b001, 8'h05, 8'h06);
        set_req(2, 3'b001, 8'h40, 8'h01);
        #1;
        check_eq("abort_ready_rst", req_ready, '0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq($sformatf("abort_norsp%0d", c), rsp_valid, '0);
        end
        reset_n = 1'b1;
        #1;
        check_eq("post_rst_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        check_eq("post_rst_alu", {alu_start, alu_op, alu_a, alu_b}, {1'b1, 3'b001, 8'h05, 8'h06});
        step();
        check_eq("post_rst_rsp", rsp_valid, 4'b0001);
        check_eq("post_rst_res", rsp_result, 16'h000B);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
